// File: rtl/sonic_pkg.sv
// sonic_pkg: shared types and constants for the echo distance path.
// State encoding, divider step count and averaging depth.
package sonic_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIV,
        S_CHECK,
        S_AVG,
        S_OUT
    } state_t;

    localparam int DIV_STEPS = 32;
    localparam int AVG_DEPTH = 4;

endpackage

// File: rtl/seq_divider.sv
// seq_divider: 32-bit restoring shift-subtract divider, MSB first.
// done is high during the final step; quotient is valid the cycle after.
module seq_divider
    import sonic_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic        done
);

    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        run_q, run_d;
    logic [32:0] shifted;
    logic [31:0] diff;
    logic        fits;

    // One quotient bit per cycle; abort wins over start.
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        fits    = shifted >= {1'b0, divisor};
        diff    = shifted[31:0] - divisor;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        if (abort) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (start) begin
            rem_d = '0;
            quo_d = dividend;
            cnt_d = 6'(DIV_STEPS);
            run_d = 1'b1;
        end else if (run_q) begin
            rem_d = fits ? diff : shifted[31:0];
            quo_d = {quo_q[30:0], fits};
            cnt_d = cnt_q - 6'd1;
            run_d = (cnt_q != 6'd1);
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign quotient = quo_q;
    assign done     = run_q & (cnt_q == 6'd1);

endmodule

// File: rtl/echo_distance.sv
// echo_distance: echo pulse width to centimetres with saturation/timeout.
// Define ECHO_DIST_AVG_EN for a 4-deep running average of in-range results.
module echo_distance
    import sonic_pkg::*;
#(
    parameter int CNT_PER_CM = 5800,
    parameter int MAX_CM     = 400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] echo_time,
    input  logic        e_done,
    input  logic        re_idle,
    output logic [15:0] dist_cm,
    output logic        dist_valid,
    output logic        range_err,
    output logic        busy
);

    state_t      state_q, state_d;
    logic        e_prev_q, r_prev_q;
    logic        e_rise, r_rise;
    logic [15:0] res_q, res_d;
    logic        err_q, err_d;
    logic [15:0] dist_q, dist_d;
    logic        valid_q, valid_d;
    logic        rerr_q, rerr_d;
    logic        busy_q, busy_d;
    logic [15:0] avg_out;
    logic        div_start;
    logic        div_done;
    logic [31:0] quotient;

    assign e_rise    = e_done & ~e_prev_q;
    assign r_rise    = re_idle & ~r_prev_q;
    assign div_start = (state_q == S_IDLE) & e_rise & ~r_rise;

    seq_divider u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .abort    (r_rise),
        .dividend (echo_time),
        .divisor  (32'(CNT_PER_CM)),
        .quotient (quotient),
        .done     (div_done)
    );

`ifdef ECHO_DIST_AVG_EN
    logic [15:0] hist_q [AVG_DEPTH];
    logic [15:0] hist_d [AVG_DEPTH];
    logic        hist_ok_q, hist_ok_d;
    logic [17:0] sum;

    // Sliding window of in-range results, prefilled by the first one.
    always_comb begin
        hist_d    = hist_q;
        hist_ok_d = hist_ok_q;
        avg_out   = res_q;
        sum       = '0;
        if (state_q == S_AVG && !err_q && !r_rise) begin
            if (!hist_ok_q) begin
                for (int i = 0; i < AVG_DEPTH; i++)
                    hist_d[i] = res_q;
                hist_ok_d = 1'b1;
            end else begin
                for (int i = 0; i < AVG_DEPTH - 1; i++)
                    hist_d[i] = hist_q[i+1];
                hist_d[AVG_DEPTH-1] = res_q;
                for (int i = 0; i < AVG_DEPTH; i++)
                    sum = sum + 18'(hist_d[i]);
                avg_out = sum[17:2];
            end
        end
    end

    // History registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < AVG_DEPTH; i++)
                hist_q[i] <= '0;
            hist_ok_q <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            hist_ok_q <= hist_ok_d;
        end
    end
`else
    // No averaging: AVG forwards the checked result.
    always_comb avg_out = res_q;
`endif

    // Conversion sequencing; a timeout edge aborts from any state.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        err_d   = err_q;
        dist_d  = dist_q;
        valid_d = 1'b0;
        rerr_d  = rerr_q;
        busy_d  = busy_q;
        if (r_rise) begin
            state_d = S_IDLE;
            dist_d  = '0;
            rerr_d  = 1'b1;
            valid_d = 1'b1;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (e_rise) begin
                        state_d = S_DIV;
                        busy_d  = 1'b1;
                    end
                end
                S_DIV: begin
                    if (div_done)
                        state_d = S_CHECK;
                end
                S_CHECK: begin
                    if (quotient > 32'(MAX_CM)) begin
                        res_d = 16'(MAX_CM);
                        err_d = 1'b1;
                    end else begin
                        res_d = quotient[15:0];
                        err_d = 1'b0;
                    end
                    state_d = S_AVG;
                end
                S_AVG: begin
                    dist_d  = avg_out;
                    rerr_d  = err_q;
                    valid_d = 1'b1;
                    state_d = S_OUT;
                end
                S_OUT: begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            e_prev_q <= 1'b0;
            r_prev_q <= 1'b0;
            res_q    <= '0;
            err_q    <= 1'b0;
            dist_q   <= '0;
            valid_q  <= 1'b0;
            rerr_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            e_prev_q <= e_done;
            r_prev_q <= re_idle;
            res_q    <= res_d;
            err_q    <= err_d;
            dist_q   <= dist_d;
            valid_q  <= valid_d;
            rerr_q   <= rerr_d;
            busy_q   <= busy_d;
        end
    end

    assign dist_cm    = dist_q;
    assign dist_valid = valid_q;
    assign range_err  = rerr_q;
    assign busy       = busy_q;

endmodule
